// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if: groups the scan controller's control inputs and decoder-facing outputs.
//   run   - level, 1 = scanning requested, 0 = stop/abort
//   mode  - 0 = continuous scan, 1 = single sweep
//   div   - dwell length minus one, in clk cycles
//   mask  - slot enable mask, bit i enables slot i
//   E     - active-high enable to the downstream 2-to-4 decoder
//   A     - slot select to the decoder, A[1] = MSB
//   busy  - high whenever the controller is not idle
//   done  - one-cycle pulse at completion of a single sweep
// master: the side driving run/mode/div/mask; slave: the controller.
interface digit_scan_ctrl_if #(
    parameter int unsigned DIV_WIDTH = 4
);
    logic                 run;
    logic                 mode;
    logic [DIV_WIDTH-1:0] div;
    logic [3:0]           mask;
    logic                 E;
    logic [1:0]           A;
    logic                 busy;
    logic                 done;

    modport master (
        output run, mode, div, mask,
        input  E, A, busy, done
    );

    modport slave (
        input  run, mode, div, mask,
        output E, A, busy, done
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed-digit scan controller driving a 2-to-4 decoder.
// Steps through the enabled slots of a latched mask in ascending order, lighting each slot
// for div+1 cycles followed by one blanking cycle so the select never changes while lit.
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - digit_scan_ctrl_if slave modport (run, mode, div, mask in; E, A, busy, done out)
module digit_scan_ctrl #(
    parameter int unsigned DIV_WIDTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    digit_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StActive, StBlank} state_e;

    state_e               state_q, state_d;
    logic [3:0]           lmask_q, lmask_d;
    logic [1:0]           a_q, a_d;
    logic                 e_q, e_d;
    logic                 done_q, done_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] dwell_q, dwell_d;
    logic                 sweep_cplt;

    // Lowest set bit of m as {found, index}.
    function automatic logic [2:0] lowest_set(input logic [3:0] m);
        logic [2:0] r;
        r = 3'b000;
        if (m[0]) begin
            r = {1'b1, 2'd0};
        end else if (m[1]) begin
            r = {1'b1, 2'd1};
        end else if (m[2]) begin
            r = {1'b1, 2'd2};
        end else if (m[3]) begin
            r = {1'b1, 2'd3};
        end
        return r;
    endfunction

    // Bits of m strictly above position cur.
    function automatic logic [3:0] bits_above(input logic [3:0] m, input logic [1:0] cur);
        logic [3:0] r;
        r = 4'b0000;
        unique case (cur)
            2'd0: r = m & 4'b1110;
            2'd1: r = m & 4'b1100;
            2'd2: r = m & 4'b1000;
            2'd3: r = 4'b0000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    logic [2:0] first_slot;
    logic [2:0] next_slot;

    always_comb begin
        first_slot = lowest_set(bus.mask);
        next_slot  = lowest_set(bits_above(lmask_q, a_q));
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lmask_q <= 4'b0000;
            a_q     <= 2'b00;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            lmask_q <= lmask_d;
            a_q     <= a_d;
            e_q     <= e_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        lmask_d    = lmask_q;
        a_d        = a_q;
        cnt_d      = cnt_q;
        dwell_d    = dwell_q;
        sweep_cplt = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.run && (bus.mask != 4'b0000)) begin
                    lmask_d = bus.mask;
                    a_d     = first_slot[1:0];
                    cnt_d   = '0;
                    dwell_d = bus.div;
                    state_d = StActive;
                end
            end

            StActive: begin
                if (!bus.run) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == dwell_q) begin
                    // Stop counting at the sampled dwell; the counter never wraps.
                    cnt_d   = '0;
                    state_d = StBlank;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StBlank: begin
                if (!bus.run) begin
                    state_d = StIdle;
                end else if (next_slot[2]) begin
                    a_d     = next_slot[1:0];
                    cnt_d   = '0;
                    dwell_d = bus.div;
                    state_d = StActive;
                end else if (bus.mode) begin
                    state_d    = StIdle;
                    sweep_cplt = 1'b1;
                end else begin
                    // Continuous mode: re-latch the mask; an empty mask ends scanning quietly.
                    lmask_d = bus.mask;
                    if (first_slot[2]) begin
                        a_d     = first_slot[1:0];
                        cnt_d   = '0;
                        dwell_d = bus.div;
                        state_d = StActive;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered-output next values and the state decode for busy.
    always_comb begin
        e_d      = (state_d == StActive);
        done_d   = sweep_cplt;
        bus.busy = (state_q != StIdle);
        bus.E    = e_q;
        bus.A    = a_q;
        bus.done = done_q;
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed scenarios plus randomized stimulus, checked every cycle against
// a slot-schedule reference model (queue of upcoming {E, A} cycles per entered slot).
module tb_digit_scan_ctrl;

    logic clk;
    logic rst_n;

    digit_scan_ctrl_if #(.DIV_WIDTH(4)) bus ();

    digit_scan_ctrl #(.DIV_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic       m_scan;
    logic       m_e;
    logic [1:0] m_a;
    logic       m_done;
    logic [3:0] m_lmask;
    logic [2:0] m_q[$];

    // Break-before-make history.
    logic       prev_valid;
    logic       prev_e;
    logic [1:0] prev_a;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Lowest set bit of m strictly above position from, or -1.
    function automatic int lowest_from(input logic [3:0] m, input int from);
        for (int i = from + 1; i < 4; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_scan  = 1'b0;
        m_e     = 1'b0;
        m_a     = 2'b00;
        m_done  = 1'b0;
        m_lmask = 4'b0000;
        m_q.delete();
    endtask

    task automatic pop_sched();
        logic [2:0] ent;
        ent = m_q.pop_front();
        m_e = ent[2];
        m_a = ent[1:0];
    endtask

    // A slot visit is div+1 lit cycles then one dark cycle, all on the same select.
    task automatic enter_slot(input int s);
        m_scan = 1'b1;
        for (int i = 0; i <= int'(bus.div); i++) m_q.push_back({1'b1, 2'(s)});
        m_q.push_back({1'b0, 2'(s)});
        pop_sched();
    endtask

    // Advance the model across one rising edge using the inputs the DUT just sampled.
    task automatic model_step();
        int nxt;
        m_done = 1'b0;
        if (!m_scan) begin
            m_e = 1'b0;
            if (bus.run && bus.mask != 4'b0000) begin
                m_lmask = bus.mask;
                enter_slot(lowest_from(bus.mask, -1));
            end
        end else if (!bus.run) begin
            m_scan = 1'b0;
            m_e    = 1'b0;
            m_q.delete();
        end else if (m_q.size() != 0) begin
            pop_sched();
        end else begin
            nxt = lowest_from(m_lmask, int'(m_a));
            if (nxt >= 0) begin
                enter_slot(nxt);
            end else if (bus.mode) begin
                m_scan = 1'b0;
                m_e    = 1'b0;
                m_done = 1'b1;
            end else begin
                m_lmask = bus.mask;
                if (bus.mask != 4'b0000) begin
                    enter_slot(lowest_from(bus.mask, -1));
                end else begin
                    m_scan = 1'b0;
                    m_e    = 1'b0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [3:0] dec;
        logic       bbm_bad;
        check("E", 8'(bus.E), 8'(m_e));
        check("A", 8'(bus.A), 8'(m_a));
        check("busy", 8'(bus.busy), 8'(m_scan));
        check("done", 8'(bus.done), 8'(m_done));
        // Select may only change after a cycle with the enable low.
        bbm_bad = prev_valid && (bus.A !== prev_a) && prev_e;
        check("break_before_make", 8'(bbm_bad), 8'd0);
        dec = bus.E ? (4'b0001 << bus.A) : 4'b0000;
        check("decoder_onehot", 8'(bus.E ? $onehot(dec) : (dec == 4'b0000)), 8'd1);
        check("lit_slot_enabled", 8'(bus.E ? m_lmask[bus.A] : 1'b1), 8'd1);
        prev_valid = 1'b1;
        prev_e     = bus.E;
        prev_a     = bus.A;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // Reset pulse between edges; outputs must clear before the next rising edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_E", 8'(bus.E), 8'd0);
        check("rst_A", 8'(bus.A), 8'd0);
        check("rst_busy", 8'(bus.busy), 8'd0);
        check("rst_done", 8'(bus.done), 8'd0);
        model_reset();
        prev_valid = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic go_idle();
        bus.run = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int waited;
        logic [3:0] rmask;
        bus.run    = 1'b0;
        bus.mode   = 1'b0;
        bus.div    = 4'd0;
        bus.mask   = 4'b0000;
        rst_n      = 1'b0;
        prev_valid = 1'b0;
        prev_e     = 1'b0;
        prev_a     = 2'b00;
        model_reset();
        #7;
        check("reset_E", 8'(bus.E), 8'd0);
        check("reset_A", 8'(bus.A), 8'd0);
        check("reset_busy", 8'(bus.busy), 8'd0);
        check("reset_done", 8'(bus.done), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous scan of all four slots, dwell 3.
        bus.mode = 1'b0; bus.mask = 4'b1111; bus.div = 4'd2; bus.run = 1'b1;
        repeat (40) step();
        go_idle();

        // Single sweep over slots 1 and 3 with a one-cycle dwell.
        bus.mode = 1'b1; bus.mask = 4'b1010; bus.div = 4'd0; bus.run = 1'b1;
        repeat (5) step();
        check("sweep_done_pulse", 8'(bus.done), 8'd1);
        bus.run = 1'b0;
        repeat (3) step();

        // Empty mask never starts a scan.
        bus.mode = 1'b0; bus.mask = 4'b0000; bus.run = 1'b1;
        repeat (20) step();
        go_idle();

        // Abort while slot 2 is lit.
        bus.mode = 1'b0; bus.mask = 4'b1111; bus.div = 4'd5; bus.run = 1'b1;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!(bus.E === 1'b1 && bus.A === 2'd2) && waited < 60);
        check("reach_slot2", 8'(waited < 60), 8'd1);
        bus.run = 1'b0;
        step();
        check("abort_E", 8'(bus.E), 8'd0);
        check("abort_busy", 8'(bus.busy), 8'd0);
        repeat (3) step();

        // Asynchronous reset mid-dwell, then restart from the lowest enabled slot.
        bus.mode = 1'b0; bus.mask = 4'b1110; bus.div = 4'd3; bus.run = 1'b1;
        repeat (7) step();
        check("lit_before_reset", 8'(bus.E), 8'd1);
        async_reset();
        step();
        check("restart_E", 8'(bus.E), 8'd1);
        check("restart_A", 8'(bus.A), 8'd1);
        repeat (10) step();
        go_idle();

        // Single enabled slot, continuous.
        bus.mode = 1'b0; bus.mask = 4'b0100; bus.div = 4'd1; bus.run = 1'b1;
        repeat (15) step();
        go_idle();

        // Randomized stimulus.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rmask    = 4'($urandom_range(0, 15));
                bus.mask = rmask;
                bus.mode = 1'($urandom_range(0, 1));
                bus.div  = 4'($urandom_range(0, 3));
            end
            bus.run = ($urandom_range(0, 19) != 0);
            step();
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
